// File: rtl/fb_rect_writer_if.sv
// Command and frame-buffer write bundle for fb_rect_writer.
//   slave  : rectangle engine side (takes commands, issues writes, reports busy/done)
//   master : draw-logic / arbiter side
// cmd_*   : rectangle origin, size and palette index with valid/ready handshake
// write_* : frame-buffer write request, held until write_ready accepts it
interface fb_rect_writer_if #(
   parameter int unsigned ADDR_W  = 19,
   parameter int unsigned COLOR_W = 8
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [9:0]         cmd_x;
   logic [9:0]         cmd_y;
   logic [9:0]         cmd_w;
   logic [9:0]         cmd_h;
   logic [COLOR_W-1:0] cmd_color;
   logic [ADDR_W-1:0]  write_address;
   logic [COLOR_W-1:0] write_data;
   logic               write_en;
   logic               write_ready;
   logic               busy;
   logic               done;

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, write_ready,
      output cmd_ready, write_address, write_data, write_en, busy, done
   );

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, write_ready,
      input  cmd_ready, write_address, write_data, write_en, busy, done
   );
endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle-fill write engine for the 640x480 8-bit-indexed frame buffer.
// Latches one fill command, walks it row-major and issues one write per pixel
// at address x + y*X_SIZE, holding each write until the arbiter accepts it.
// Ports:
//   Clk   : clock, rising edge
//   Reset : asynchronous, active-high
//   bus   : fb_rect_writer_if.slave (cmd_* in, write_* out, busy, done)
// Build option: define FB_RECT_CLIP_EN to skip pixels outside X_SIZE x Y_SIZE
// (one cycle per skipped pixel with write_en low).
module fb_rect_writer #(
   parameter int unsigned X_SIZE  = 640,
   parameter int unsigned Y_SIZE  = 480,
   parameter int unsigned ADDR_W  = 19,
   parameter int unsigned COLOR_W = 8
) (
   input logic             Clk,
   input logic             Reset,
   fb_rect_writer_if.slave bus
);
   localparam logic [0:0]  S_IDLE = 1'b0;
   localparam logic [0:0]  S_RUN  = 1'b1;
   localparam int unsigned CW     = 11;   // column/row span incl. x+w overflow

   // Zero-sized frames are not a meaningful configuration.
   if (X_SIZE == 0 || Y_SIZE == 0) begin : g_bad_frame_size
   end

   logic [0:0]         state_q, state_d;
   logic [CW-1:0]      col_q, col_d;
   logic [CW-1:0]      x0_q, x0_d;
   logic [CW-1:0]      xend_q, xend_d;
   logic [9:0]         rows_q, rows_d;
   logic [ADDR_W-1:0]  row_base_q, row_base_d;
   logic [ADDR_W-1:0]  write_address_q, write_address_d;
   logic [COLOR_W-1:0] write_data_q, write_data_d;
   logic               write_en_q, write_en_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               step;
   logic               run_next;
`ifdef FB_RECT_CLIP_EN
   logic [CW-1:0]      row_q, row_d;
`endif

   // y*X_SIZE as a sum of shifted copies of y, one per set bit of X_SIZE.
   function automatic logic [ADDR_W-1:0] row_base_of(input logic [9:0] y);
      logic [ADDR_W-1:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (((X_SIZE >> i) & 32'd1) != 32'd0) acc = acc + (ADDR_W'(y) << i);
      end
      return acc;
   endfunction

   // Next-state, walk and output computation.
   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      x0_d          = x0_q;
      xend_d        = xend_q;
      rows_d        = rows_q;
      row_base_d    = row_base_q;
      write_data_d  = write_data_q;
      done_d        = 1'b0;
      step          = 1'b0;
`ifdef FB_RECT_CLIP_EN
      row_d         = row_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               if (bus.cmd_w == 10'd0 || bus.cmd_h == 10'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d      = S_RUN;
                  x0_d         = CW'(bus.cmd_x);
                  col_d        = CW'(bus.cmd_x);
                  xend_d       = CW'(bus.cmd_x) + CW'(bus.cmd_w);
                  rows_d       = bus.cmd_h;
                  row_base_d   = row_base_of(bus.cmd_y);
                  write_data_d = bus.cmd_color;
`ifdef FB_RECT_CLIP_EN
                  row_d        = CW'(bus.cmd_y);
`endif
               end
            end
         end
         S_RUN: begin
`ifdef FB_RECT_CLIP_EN
            // Skipped pixels advance unconditionally.
            step = write_en_q ? bus.write_ready : 1'b1;
`else
            step = bus.write_ready;
`endif
            if (step) begin
               if (CW'(col_q + CW'(1)) == xend_q) begin
                  if (rows_q == 10'd1) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     col_d      = x0_q;
                     rows_d     = rows_q - 10'd1;
                     row_base_d = row_base_q + ADDR_W'(X_SIZE);
`ifdef FB_RECT_CLIP_EN
                     row_d      = row_q + CW'(1);
`endif
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      run_next        = (state_d == S_RUN);
      write_address_d = row_base_d + ADDR_W'(col_d);
`ifdef FB_RECT_CLIP_EN
      write_en_d      = run_next && (col_d < CW'(X_SIZE)) && (row_d < CW'(Y_SIZE));
`else
      write_en_d      = run_next;
`endif
      cmd_ready_d     = !run_next;
      busy_d          = run_next;
   end

   // State and registered outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q         <= S_IDLE;
         col_q           <= '0;
         x0_q            <= '0;
         xend_q          <= '0;
         rows_q          <= '0;
         row_base_q      <= '0;
         write_address_q <= '0;
         write_data_q    <= '0;
         write_en_q      <= 1'b0;
         cmd_ready_q     <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
`ifdef FB_RECT_CLIP_EN
         row_q           <= '0;
`endif
      end else begin
         state_q         <= state_d;
         col_q           <= col_d;
         x0_q            <= x0_d;
         xend_q          <= xend_d;
         rows_q          <= rows_d;
         row_base_q      <= row_base_d;
         write_address_q <= write_address_d;
         write_data_q    <= write_data_d;
         write_en_q      <= write_en_d;
         cmd_ready_q     <= cmd_ready_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
`ifdef FB_RECT_CLIP_EN
         row_q           <= row_d;
`endif
      end
   end

   assign bus.cmd_ready     = cmd_ready_q;
   assign bus.write_address = write_address_q;
   assign bus.write_data    = write_data_q;
   assign bus.write_en      = write_en_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
endmodule
